// File: rtl/sfq_deser_pkg.sv
// -----------------------------------------------------------------------------
// sfq_deser_pkg
//
// Purpose:
//   Shared constants and helpers for the toggle-encoded SFQ deserializer.
//
// Contents:
//   DEFAULT_WIDTH  default number of bits packed into one output word
//   MIN_WIDTH      smallest supported word width
//   MAX_WIDTH      largest supported word width
//   clog2_min1()   index width for a given word width, never less than 1
// -----------------------------------------------------------------------------
package sfq_deser_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int MIN_WIDTH     = 2;
    localparam int MAX_WIDTH     = 32;

    // Width of a bit index that can address 0..n-1. A width of 1 is returned
    // for n <= 2 so that index vectors are never zero-width.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage : sfq_deser_pkg

// File: rtl/sfq_deser_fifo2.sv
// -----------------------------------------------------------------------------
// sfq_deser_fifo2
//
// Purpose:
//   Two-entry valid/ready buffer for completed words. The head entry is a
//   register that drives the consumer directly, so the output data and its
//   valid are both registered. A second register holds a word that arrives
//   while the head is still waiting for the consumer.
//
//   A push while both entries are held is accepted only when a pop happens in
//   the same cycle; otherwise the pushed word is discarded and the held words
//   are left untouched. Reporting of a discarded push is left to the parent.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset, empties the buffer
//   push_i       in   write push_data_i this cycle
//   push_data_i  in   word to write
//   pop_i        in   consumer accepts the head word (ignored when empty)
//   head_o       out  registered head word
//   full_o       out  both entries hold a word
//   empty_o      out  no word held; head_o is not meaningful
// -----------------------------------------------------------------------------
module sfq_deser_fifo2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic          head_vld_q, head_vld_d;
    logic          tail_vld_q, tail_vld_d;
    logic          pop;

    // A pop request on an empty buffer has no effect.
    assign pop = pop_i & head_vld_q;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        head_vld_d = head_vld_q;
        tail_vld_d = tail_vld_q;

        if (pop) begin
            if (tail_vld_q) begin
                // Second entry advances to the head; a simultaneous push
                // takes the freed second slot.
                head_d     = tail_q;
                head_vld_d = 1'b1;
                tail_vld_d = push_i;
                if (push_i) begin
                    tail_d = push_data_i;
                end
            end else begin
                head_vld_d = push_i;
                if (push_i) begin
                    head_d = push_data_i;
                end
            end
        end else if (push_i) begin
            if (!head_vld_q) begin
                head_d     = push_data_i;
                head_vld_d = 1'b1;
            end else if (!tail_vld_q) begin
                tail_d     = push_data_i;
                tail_vld_d = 1'b1;
            end
            // Both entries held and no pop: the new word is discarded.
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the data registers are reset along with the valid bits
            // because head_q drives the word output, which must read 0 after
            // reset; a plain storage array with a separate valid would not need it.
            head_q     <= '0;
            tail_q     <= '0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            head_vld_q <= head_vld_d;
            tail_vld_q <= tail_vld_d;
        end
    end

    assign head_o  = head_q;
    assign full_o  = head_vld_q & tail_vld_q;
    assign empty_o = ~head_vld_q;

endmodule : sfq_deser_fifo2

// File: rtl/sfq_toggle_deser.sv
// -----------------------------------------------------------------------------
// sfq_toggle_deser
//
// Purpose:
//   Cycle-based receiver for the output of a clocked RSFQ cell. Both the data
//   line and the bit-slot strobe are toggle encoded: every level change is one
//   SFQ pulse. A slot is closed by each strobe pulse; the recovered bit is 1
//   when at least one data pulse arrived during the slot (including a data
//   pulse in the same cycle as the closing strobe). Bits are packed LSB first
//   into WIDTH-bit words that are handed to a 2-entry valid/ready buffer.
//
// Parameters:
//   WIDTH   bits per word (2..32)
//   INVERT  1 = complement every recovered bit before packing
//
// Ports:
//   clk      in   sampling clock, all state changes on its rising edge
//   rst_n    in   synchronous active-low reset
//   d_tgl    in   toggle-encoded data pulse line
//   s_tgl    in   toggle-encoded slot strobe
//   sync     in   discard the partial word and restart at bit 0
//   clr_err  in   clear the sticky error flags
//   m_data   out  output word
//   m_valid  out  m_data holds a word
//   m_ready  in   consumer accepts the word when m_valid is 1
//   ovf      out  sticky: a completed word was dropped (buffer full)
//   dbl      out  sticky: more than one data pulse fell in one slot
//   bit_idx  out  index of the next bit to be written
// -----------------------------------------------------------------------------
module sfq_toggle_deser
    import sfq_deser_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter bit INVERT = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         d_tgl,
    input  logic                         s_tgl,
    input  logic                         sync,
    input  logic                         clr_err,
    output logic [WIDTH-1:0]             m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         ovf,
    output logic                         dbl,
    output logic [clog2_min1(WIDTH)-1:0] bit_idx
);

    localparam int IDX_W = clog2_min1(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    // Line history for pulse (edge) detection.
    logic             d_prev_q, s_prev_q;
    logic             d_ev, s_ev;

    // Slot and word assembly state.
    logic             slot_hit_q, slot_hit_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;

    // Sticky error flags.
    logic             ovf_q, ovf_d;
    logic             dbl_q, dbl_d;

    // Slot-close helpers.
    logic             bit_val;
    logic             last_slot;
    logic [WIDTH-1:0] word_full;
    logic             push;
    logic             dbl_set;
    logic             ovf_set;

    // Buffer interface.
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    assign d_ev = d_tgl ^ d_prev_q;
    assign s_ev = s_tgl ^ s_prev_q;

    // A data pulse coinciding with the strobe belongs to the slot being closed.
    assign bit_val   = (slot_hit_q | d_ev) ^ INVERT;
    assign last_slot = (bit_idx_q == LAST_IDX);

    // The completing bit is merged combinationally so the word enters the
    // buffer on the same edge that samples the last strobe pulse.
    always_comb begin
        word_full            = sreg_q;
        word_full[bit_idx_q] = bit_val;
    end

    assign push    = ~sync & s_ev & last_slot;
    assign pop     = ~fifo_empty & m_ready;
    assign ovf_set = push & fifo_full & ~pop;

    // A second pulse in a slot is an error whether it arrives on its own or
    // together with the closing strobe; sync suppresses both.
    assign dbl_set = ~sync & d_ev & slot_hit_q;

    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no
        // path through the branches below can leave one unassigned (latch).
        slot_hit_d = slot_hit_q;
        sreg_d     = sreg_q;
        bit_idx_d  = bit_idx_q;

        if (sync) begin
            // Realignment wins over any pulse seen in this cycle.
            slot_hit_d = 1'b0;
            sreg_d     = '0;
            bit_idx_d  = '0;
        end else if (s_ev) begin
            slot_hit_d = 1'b0;
            if (last_slot) begin
                sreg_d    = '0;
                bit_idx_d = '0;
            end else begin
                sreg_d    = word_full;
                bit_idx_d = bit_idx_q + IDX_W'(1);
            end
        end else if (d_ev) begin
            slot_hit_d = 1'b1;
        end

        // Set wins over clear when both happen in one cycle.
        ovf_d = (ovf_q & ~clr_err) | ovf_set;
        dbl_d = (dbl_q & ~clr_err) | dbl_set;
    end

    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples the values from before this edge, independent of statement order.
        d_prev_q <= d_tgl;
        s_prev_q <= s_tgl;
        if (!rst_n) begin
            // Line history still tracks the inputs so that levels held across
            // reset release do not look like pulses.
            slot_hit_q <= 1'b0;
            sreg_q     <= '0;
            bit_idx_q  <= '0;
            ovf_q      <= 1'b0;
            dbl_q      <= 1'b0;
        end else begin
            slot_hit_q <= slot_hit_d;
            sreg_q     <= sreg_d;
            bit_idx_q  <= bit_idx_d;
            ovf_q      <= ovf_d;
            dbl_q      <= dbl_d;
        end
    end

    sfq_deser_fifo2 #(
        .DW (WIDTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (word_full),
        .pop_i       (m_ready),
        .head_o      (m_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign m_valid = ~fifo_empty;
    assign ovf     = ovf_q;
    assign dbl     = dbl_q;
    assign bit_idx = bit_idx_q;

endmodule : sfq_toggle_deser

// File: tb/tb_sfq_toggle_deser.sv
// -----------------------------------------------------------------------------
// tb_sfq_toggle_deser
//
// Drives two deserializers (INVERT=0 and INVERT=1) from the same toggle lines
// and compares their outputs against hand-computed words.
// -----------------------------------------------------------------------------
module tb_sfq_toggle_deser;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         d_tgl;
    logic         s_tgl;
    logic         sync;
    logic         clr_err;
    logic         m_ready;

    logic [W-1:0] m_data,  m_data_inv;
    logic         m_valid, m_valid_inv;
    logic         ovf,     ovf_inv;
    logic         dbl,     dbl_inv;
    logic [2:0]   bit_idx, bit_idx_inv;

    int total;
    int bad;

    sfq_toggle_deser #(.WIDTH(W), .INVERT(1'b0)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_tgl   (d_tgl),
        .s_tgl   (s_tgl),
        .sync    (sync),
        .clr_err (clr_err),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .ovf     (ovf),
        .dbl     (dbl),
        .bit_idx (bit_idx)
    );

    sfq_toggle_deser #(.WIDTH(W), .INVERT(1'b1)) dut_inv (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_tgl   (d_tgl),
        .s_tgl   (s_tgl),
        .sync    (sync),
        .clr_err (clr_err),
        .m_data  (m_data_inv),
        .m_valid (m_valid_inv),
        .m_ready (m_ready),
        .ovf     (ovf_inv),
        .dbl     (dbl_inv),
        .bit_idx (bit_idx_inv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] pattern;   // data pulse per slot, bit i = slot i
        logic         coinc0;    // slot 0 data pulse shares the strobe cycle
        logic [W-1:0] exp_word;  // expected word, INVERT=0
        logic [W-1:0] exp_inv;   // expected word, INVERT=1
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic slot(input logic b);
        if (b) d_tgl = ~d_tgl;
        cyc();
        s_tgl = ~s_tgl;
        cyc();
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic coinc0);
        logic [W-1:0] tmp;
        tmp = w;
        for (int i = 0; i < W; i++) begin
            if (i == 0 && coinc0) begin
                if (tmp[0]) d_tgl = ~d_tgl;
                s_tgl = ~s_tgl;
                cyc();
            end else begin
                slot(tmp[i]);
            end
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        d_tgl   = 1'b0;
        s_tgl   = 1'b0;
        sync    = 1'b0;
        clr_err = 1'b0;
        m_ready = 1'b1;

        vecs[0] = '{8'h3C, 1'b0, 8'h3C, 8'hC3};
        vecs[1] = '{8'h8D, 1'b0, 8'h8D, 8'h72};
        vecs[2] = '{8'h01, 1'b1, 8'h01, 8'hFE};
        vecs[3] = '{8'h00, 1'b0, 8'h00, 8'hFF};
        vecs[4] = '{8'hFF, 1'b0, 8'hFF, 8'h00};
        vecs[5] = '{8'hA5, 1'b1, 8'hA5, 8'h5A};

        // ---- reset with both lines high, then release ----
        cyc();
        d_tgl = 1'b1;
        s_tgl = 1'b1;
        cyc();
        cyc();
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data",  32'(m_data),  32'd0);
        check("rst_ovf",     32'(ovf),     32'd0);
        check("rst_dbl",     32'(dbl),     32'd0);
        check("rst_bit_idx", 32'(bit_idx), 32'd0);
        rst_n = 1'b1;
        repeat (3) cyc();
        check("rel_bit_idx", 32'(bit_idx), 32'd0);
        check("rel_m_valid", 32'(m_valid), 32'd0);
        check("rel_dbl",     32'(dbl),     32'd0);
        check("rel_m_data",  32'(m_data_inv), 32'd0);

        // ---- table-driven words, consumer always ready ----
        for (int v = 0; v < 6; v++) begin
            send_word(vecs[v].pattern, vecs[v].coinc0);
            check($sformatf("v%0d_valid", v),   32'(m_valid),     32'd1);
            check($sformatf("v%0d_data", v),    32'(m_data),      32'(vecs[v].exp_word));
            check($sformatf("v%0d_inv", v),     32'(m_data_inv),  32'(vecs[v].exp_inv));
            check($sformatf("v%0d_bit_idx", v), 32'(bit_idx),     32'd0);
            cyc();
            check($sformatf("v%0d_pulse", v),   32'(m_valid),     32'd0);
            check($sformatf("v%0d_dbl", v),     32'(dbl),         32'd0);
        end

        // ---- double pulse in slot 4 ----
        for (int i = 0; i < W; i++) begin
            if (i == 4) begin
                d_tgl = ~d_tgl;
                cyc();
                d_tgl = ~d_tgl;
                cyc();
                s_tgl = ~s_tgl;
                cyc();
            end else begin
                slot(1'b0);
            end
        end
        check("dbl_word",  32'(m_data), 32'h10);
        check("dbl_valid", 32'(m_valid), 32'd1);
        check("dbl_set",   32'(dbl),    32'd1);
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        check("dbl_clr", 32'(dbl), 32'd0);
        // New double pulse together with clr_err: set wins.
        d_tgl = ~d_tgl;
        cyc();
        d_tgl   = ~d_tgl;
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        check("dbl_set_wins", 32'(dbl), 32'd1);
        // Drop the partial slot and clear the flag again.
        sync    = 1'b1;
        clr_err = 1'b1;
        cyc();
        sync    = 1'b0;
        clr_err = 1'b0;
        check("dbl_clr2",   32'(dbl),     32'd0);
        check("sync_idx_a", 32'(bit_idx), 32'd0);

        // ---- overflow: three words with the consumer stalled ----
        m_ready = 1'b0;
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        check("stall_hold", 32'(m_data), 32'h11);
        check("stall_ovf0", 32'(ovf),    32'd0);
        send_word(8'h33, 1'b0);
        check("ovf_set",    32'(ovf),     32'd1);
        check("ovf_head",   32'(m_data),  32'h11);
        check("ovf_valid",  32'(m_valid), 32'd1);
        m_ready = 1'b1;
        cyc();
        check("ovf_second", 32'(m_data),  32'h22);
        check("ovf_valid2", 32'(m_valid), 32'd1);
        cyc();
        check("ovf_empty",  32'(m_valid), 32'd0);
        check("ovf_sticky", 32'(ovf),     32'd1);
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        check("ovf_clr", 32'(ovf), 32'd0);

        // ---- sync after 3 slots, with a strobe in the sync cycle ----
        slot(1'b1);
        slot(1'b1);
        slot(1'b1);
        check("pre_sync_idx", 32'(bit_idx), 32'd3);
        sync  = 1'b1;
        s_tgl = ~s_tgl;
        d_tgl = ~d_tgl;
        cyc();
        sync = 1'b0;
        check("sync_idx", 32'(bit_idx), 32'd0);
        check("sync_no_word", 32'(m_valid), 32'd0);
        send_word(8'h5C, 1'b0);
        check("sync_word",  32'(m_data),  32'h5C);
        check("sync_valid", 32'(m_valid), 32'd1);
        check("sync_dbl",   32'(dbl),     32'd0);
        cyc();

        // ---- reset mid-word with a held word ----
        m_ready = 1'b0;
        send_word(8'h77, 1'b0);
        slot(1'b1);
        slot(1'b0);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        check("mrst_valid", 32'(m_valid), 32'd0);
        check("mrst_idx",   32'(bit_idx), 32'd0);
        check("mrst_data",  32'(m_data),  32'd0);
        m_ready = 1'b1;
        send_word(8'h42, 1'b0);
        check("mrst_word",  32'(m_data),  32'h42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sfq_toggle_deser
